// File: rtl/cache_pkg.sv
// Shared cache constants and fill-FSM state encoding.
package cache_pkg;

   localparam int unsigned ADDR_W          = 16;
   localparam int unsigned WORDS_PER_BLOCK = 8;
   localparam int unsigned OFFSET_W        = 4;
   localparam int unsigned WORD_IDX_W      = 3;
   localparam int unsigned CNT_W           = 4;

   typedef enum logic {IDLE, FILL} fill_state_t;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for block fills: clears on request, counts when enabled, holds at WORDS_PER_BLOCK.
module fill_counter
   import cache_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt_q
);

   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q < CNT_W'(WORDS_PER_BLOCK))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: stalls the requestor, streams eight word reads from main memory
// into the data array, and writes the tag with the last returned word.
module cache_fill_fsm
   import cache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  miss_detected,
   input  logic [ADDR_W-1:0]     miss_address,
   input  logic                  memory_data_valid,
   output logic                  fsm_busy,
   output logic                  mem_en,
   output logic [ADDR_W-1:0]     memory_address,
   output logic                  write_data_array,
   output logic [WORD_IDX_W-1:0] fill_word,
   output logic                  write_tag_array
);

   localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((2 ** OFFSET_W) - 1);

   fill_state_t       state_q, state_d;
   logic [ADDR_W-1:0] base_addr_q, base_addr_d;
   logic [CNT_W-1:0]  issue_cnt_q, rcv_cnt_q;
   logic              cnt_clr;

   fill_counter u_issue_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (mem_en),
      .cnt_q (issue_cnt_q)
   );

   fill_counter u_rcv_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (write_data_array),
      .cnt_q (rcv_cnt_q)
   );

   // Address and word index come straight from registers, so they are never X after reset.
   assign memory_address = base_addr_q + ADDR_W'({issue_cnt_q[WORD_IDX_W-1:0], 1'b0});
   assign fill_word      = rcv_cnt_q[WORD_IDX_W-1:0];

   always_comb begin
      state_d          = state_q;
      base_addr_d      = base_addr_q;
      cnt_clr          = 1'b0;
      fsm_busy         = 1'b0;
      mem_en           = 1'b0;
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Busy follows the miss combinationally so the pipeline stalls in the miss cycle.
            fsm_busy = miss_detected;
            if (miss_detected) begin
               base_addr_d = miss_address & BLOCK_MASK;
               cnt_clr     = 1'b1;
               state_d     = FILL;
            end
         end
         FILL: begin
            fsm_busy         = 1'b1;
            mem_en           = (issue_cnt_q < CNT_W'(WORDS_PER_BLOCK));
            write_data_array = memory_data_valid && (rcv_cnt_q < CNT_W'(WORDS_PER_BLOCK));
            write_tag_array  = write_data_array && (rcv_cnt_q == CNT_W'(WORDS_PER_BLOCK - 1));
            if (write_tag_array) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         base_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         base_addr_q <= base_addr_d;
      end
   end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss handler that sits between the pipeline's I-cache/D-cache and the multicycle main memory.
- On a miss it stalls the pipeline via fsm_busy, issues 8 consecutive word reads for the 16-byte block, and writes each returned word into the data array.
- On the last word it writes the tag array.
- One instance per cache. The cpu top-level ORs the fsm_busy outputs into the PC/IF_ID stall path alongside the hazard unit.

Parameters:
- ADDR_W, 16, byte address width.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block (power of two).
- OFFSET_W, 4, byte-offset bits within a block (log2(2*WORDS_PER_BLOCK)).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- miss_detected  in  1  cache lookup missed this cycle.
- miss_address  in  ADDR_W  address that missed; bits [OFFSET_W-1:0] ignored.
- memory_data_valid  in  1  main memory returns one word this cycle.
- fsm_busy  out  1  fill in progress; stall requestor.
- mem_en  out  1  issue read request to main memory this cycle.
- memory_address  out  ADDR_W  byte address of the request being issued.
- write_data_array  out  1  write returned word into the data array.
- fill_word  out  log2(WORDS_PER_BLOCK)  word offset targeted by write_data_array.
- write_tag_array  out  1  write tag and valid bit for the filled block.

Interface:
- One clock (clk).
- Reset rst_n is asynchronous and active-low.

Behaviour:
- States: IDLE, FILL.
- Internal registers:
  - base_addr: block-aligned, ADDR_W bits.
  - issue_cnt: 0..8.
  - rcv_cnt: 0..8.
- Reset (asynchronous, any state, including mid-fill):
  - state=IDLE; base_addr=0; issue_cnt=0; rcv_cnt=0.
  - All outputs 0.
  - In-flight memory responses arriving after reset are ignored, because IDLE ignores memory_data_valid.
- IDLE:
  - mem_en=0, write_data_array=0, write_tag_array=0.
  - fsm_busy = miss_detected (combinational, so the requestor stalls in the miss cycle itself).
  - On miss_detected: latch base_addr = {miss_address[ADDR_W-1:OFFSET_W], OFFSET_W'b0}, clear both counters, go to FILL.
- FILL:
  - fsm_busy=1.
  - Issue:
    - mem_en = (issue_cnt < WORDS_PER_BLOCK).
    - memory_address = base_addr + 2*issue_cnt[2:0].
    - issue_cnt increments each cycle mem_en=1 and saturates at 8.
    - Result: one request per cycle for 8 consecutive cycles, starting the cycle after the miss.
  - Receive:
    - write_data_array = memory_data_valid && (rcv_cnt < WORDS_PER_BLOCK).
    - fill_word = rcv_cnt[2:0].
    - rcv_cnt increments on each write_data_array.
  - Completion:
    - write_tag_array = write_data_array && rcv_cnt == WORDS_PER_BLOCK-1 (same cycle as the 8th data write).
    - Next state is IDLE; fsm_busy drops the following cycle.
- Latency independence: the FSM counts responses, not cycles, so any memory latency ≥1 and any gaps in memory_data_valid are tolerated.
- With 4-cycle memory, a miss at cycle 0 behaves as follows:
  - Requests issue in cycles 1–8.
  - Data arrives in cycles 5–12.
  - Tag write occurs in cycle 12.
  - fsm_busy is high for cycles 0–12 (13 stall cycles).
- Boundary conditions:
  - miss_detected while in FILL: ignored; miss_address is not re-latched.
  - memory_data_valid in IDLE, or after 8 words: no write, no counter change.
  - miss_detected in the same cycle the FSM returns to IDLE (cycle after tag write): a new fill starts normally.
  - memory_address arithmetic wraps modulo 2^ADDR_W. Wrap cannot occur within a block because base_addr is block-aligned.
- Outputs memory_address and fill_word are don't-care when their qualifier (mem_en, write_data_array) is 0. They are driven from registers and must not be X after reset.

Decomposition:
- cache_pkg holds:
  - typedef enum logic {IDLE, FILL} fill_state_t.
  - Constants WORDS_PER_BLOCK, OFFSET_W, WORD_IDX_W.
  - The same package is used by cache/cache_model and verification tasks.
- Sub-module fill_counter: 4-bit up-counter with synchronous clear, enable, saturate-at-8, and async reset.
  - Instantiated twice, for issue_cnt and rcv_cnt.
- Top-level FSM and address mux stay in cache_fill_fsm.

Test Plan:
- Reset check: after rst_n deasserts, all outputs are 0. With miss_detected=0 for 10 cycles, fsm_busy=0 and mem_en=0 throughout.
- Basic fill, 4-cycle memory, miss_address=0x1236 at cycle 0:
  - fsm_busy is 1 for cycles 0–12.
  - memory_address is 0x1230, 0x1232, …, 0x123E in cycles 1–8, with mem_en=1 exactly in those cycles.
  - write_data_array is 1 in cycles 5–12 with fill_word 0..7.
  - write_tag_array is 1 only in cycle 12.
- Irregular memory: memory_data_valid pulses with 0–3 idle gaps between pulses.
  - Exactly 8 writes occur, with fill_word 0..7 in order.
  - write_tag_array coincides with the 8th write.
  - fsm_busy stays high until the cycle after the 8th write.
- Spurious and extra inputs:
  - Toggling miss_detected with miss_address=0xFFF0 mid-fill does not change memory_address (base stays 0x1230).
  - A 9th memory_data_valid after the tag write produces no write_data_array.
- Back-to-back misses: a new miss at 0xFFF0 in the cycle after the tag write issues requests 0xFFF0…0xFFFE with no lost cycle.
- Reset mid-fill: assert rst_n=0 at cycle 6.
  - All outputs go to 0 immediately, before the next clk edge.
  - After release, memory_data_valid pulses cause no writes, and a new miss fills cleanly from fill_word 0.
